// File: rtl/mips_stats_pkg.sv
// mips_stats_pkg
// Shared definitions for the retired-instruction statistics block and its
// opcode decoder: MIPS opcode constants, the 2-bit class encoding and the
// bit positions inside the sticky overflow vector.
//
// Optional feature macro: STATS_SUBCLASS_EN
//   When defined, the overflow vector carries two extra bits for the
//   branch (BEQ/BNE) and memory (LW/SW) sub-class counters.

package mips_stats_pkg;

  // Opcodes recognised by the decoder
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Instruction class encoding
  typedef enum logic [1:0] {
    CLS_R   = 2'd0,
    CLS_I   = 2'd1,
    CLS_J   = 2'd2,
    CLS_UNK = 2'd3
  } op_cls_e;

  // Bit positions in the ovf vector
  localparam int OVF_R     = 0;
  localparam int OVF_I     = 1;
  localparam int OVF_J     = 2;
  localparam int OVF_UNK   = 3;
  localparam int OVF_TOTAL = 4;
  localparam int OVF_BR    = 5;
  localparam int OVF_MEM   = 6;

`ifdef STATS_SUBCLASS_EN
  localparam int OVF_W = 7;
`else
  localparam int OVF_W = 5;
`endif

endpackage

// File: rtl/op_class_decode.sv
// op_class_decode
// Purely combinational MIPS opcode classifier.
//
// Ports:
//   op      in   6  opcode field of the instruction
//   cls     out  2  class: CLS_R / CLS_I / CLS_J / CLS_UNK
//   is_br   out  1  opcode is BEQ or BNE
//   is_mem  out  1  opcode is LW or SW
//
// Branch and memory opcodes are I-type as well; the two flags are
// refinements, not separate classes.

module op_class_decode
  import mips_stats_pkg::*;
(
  input  logic [5:0] op,
  output op_cls_e    cls,
  output logic       is_br,
  output logic       is_mem
);

  always_comb begin
    cls    = CLS_UNK;
    is_br  = 1'b0;
    is_mem = 1'b0;
    case (op)
      OP_RTYPE: cls = CLS_R;
      OP_J,
      OP_JAL:   cls = CLS_J;
      OP_ADDI,
      OP_ADDIU,
      OP_SLTI,
      OP_ANDI,
      OP_ORI:   cls = CLS_I;
      OP_BEQ,
      OP_BNE: begin
        cls   = CLS_I;
        is_br = 1'b1;
      end
      OP_LW,
      OP_SW: begin
        cls    = CLS_I;
        is_mem = 1'b1;
      end
      default:  cls = CLS_UNK;
    endcase
  end

endmodule

// File: rtl/instr_class_stats.sv
// instr_class_stats
// Per-class retired-instruction counters with sticky overflow flags,
// synchronous clear and a coherent snapshot register bank.
//
// Parameters:
//   CNT_W     width of every counter and snapshot register (>= 4)
//   SATURATE  1: counters hold at all-ones on overflow, 0: wrap to 0
//
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   ret_valid, ret_op        retire strobe and opcode of retiring instr
//   clear                    synchronous clear of counters and ovf
//   snap_req                 capture all live counters into snap_*
//   cnt_r/i/j/unk/total      live counters
//   ovf                      sticky overflow flags {total, unk, j, i, r}
//   snap_valid               one-cycle pulse after a snapshot capture
//   snap_r/i/j/unk/total     snapshot registers
//
// Optional feature macro: STATS_SUBCLASS_EN
//   Adds cnt_br/cnt_mem and snap_br/snap_mem; ovf grows to
//   {mem, br, total, unk, j, i, r}.
//
// Pipeline: the opcode is decoded and registered on edge N (stage 1) and
// the counters update on edge N+1 (stage 2). No back-pressure.
//
// Snapshot handshake: snap_req has no ready; a request sampled on an edge
// is always accepted, and snap_valid is high for exactly the next cycle,
// during which snap_* hold the counter values from just before that edge.
// The snap_* registers keep that data until the next request.

module instr_class_stats
  import mips_stats_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ret_valid,
  input  logic [5:0]       ret_op,
  input  logic             clear,
  input  logic             snap_req,
  output logic [CNT_W-1:0] cnt_r,
  output logic [CNT_W-1:0] cnt_i,
  output logic [CNT_W-1:0] cnt_j,
  output logic [CNT_W-1:0] cnt_unk,
  output logic [CNT_W-1:0] cnt_total,
`ifdef STATS_SUBCLASS_EN
  output logic [CNT_W-1:0] cnt_br,
  output logic [CNT_W-1:0] cnt_mem,
  output logic [CNT_W-1:0] snap_br,
  output logic [CNT_W-1:0] snap_mem,
`endif
  output logic [OVF_W-1:0] ovf,
  output logic             snap_valid,
  output logic [CNT_W-1:0] snap_r,
  output logic [CNT_W-1:0] snap_i,
  output logic [CNT_W-1:0] snap_j,
  output logic [CNT_W-1:0] snap_unk,
  output logic [CNT_W-1:0] snap_total
);

  // Next value of a counter on increment; MSB flags an overflow.
  function automatic logic [CNT_W:0] bump(input logic [CNT_W-1:0] v);
    logic [CNT_W:0] r;
    if (&v) r = {1'b1, (SATURATE ? v : {CNT_W{1'b0}})};
    else    r = {1'b0, v + CNT_W'(1)};
    return r;
  endfunction

  // ---------------------------------------------------------------- decode
  op_cls_e dec_cls;
  logic    dec_br;
  logic    dec_mem;

  op_class_decode u_decode (
    .op     (ret_op),
    .cls    (dec_cls),
    .is_br  (dec_br),
    .is_mem (dec_mem)
  );

  // ---------------------------------------------------------------- stage 1
  logic    s1_valid;
  op_cls_e s1_cls;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_cls   <= CLS_R;
    end else begin
      s1_valid <= ret_valid;
      s1_cls   <= dec_cls;
    end
  end

`ifdef STATS_SUBCLASS_EN
  logic s1_br;
  logic s1_mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_br  <= 1'b0;
      s1_mem <= 1'b0;
    end else begin
      s1_br  <= dec_br;
      s1_mem <= dec_mem;
    end
  end
`else
  logic unused_dec_flags;
  assign unused_dec_flags = dec_br ^ dec_mem;
`endif

  // ---------------------------------------------------------------- stage 2
  logic inc_r, inc_i, inc_j, inc_unk, inc_total;
  logic [CNT_W:0] nx_r, nx_i, nx_j, nx_unk, nx_total;

  assign inc_r     = s1_valid && (s1_cls == CLS_R);
  assign inc_i     = s1_valid && (s1_cls == CLS_I);
  assign inc_j     = s1_valid && (s1_cls == CLS_J);
  assign inc_unk   = s1_valid && (s1_cls == CLS_UNK);
  assign inc_total = s1_valid;

  assign nx_r     = bump(cnt_r);
  assign nx_i     = bump(cnt_i);
  assign nx_j     = bump(cnt_j);
  assign nx_unk   = bump(cnt_unk);
  assign nx_total = bump(cnt_total);

  // Clear wins over the stage-1 entry at the same edge: that entry is
  // dropped, while the instruction arriving at that edge still enters
  // stage 1 and is counted one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r     <= '0;
      cnt_i     <= '0;
      cnt_j     <= '0;
      cnt_unk   <= '0;
      cnt_total <= '0;
      ovf[OVF_TOTAL:OVF_R] <= '0;
    end else if (clear) begin
      cnt_r     <= '0;
      cnt_i     <= '0;
      cnt_j     <= '0;
      cnt_unk   <= '0;
      cnt_total <= '0;
      ovf[OVF_TOTAL:OVF_R] <= '0;
    end else begin
      if (inc_r) begin
        cnt_r      <= nx_r[CNT_W-1:0];
        ovf[OVF_R] <= ovf[OVF_R] | nx_r[CNT_W];
      end
      if (inc_i) begin
        cnt_i      <= nx_i[CNT_W-1:0];
        ovf[OVF_I] <= ovf[OVF_I] | nx_i[CNT_W];
      end
      if (inc_j) begin
        cnt_j      <= nx_j[CNT_W-1:0];
        ovf[OVF_J] <= ovf[OVF_J] | nx_j[CNT_W];
      end
      if (inc_unk) begin
        cnt_unk      <= nx_unk[CNT_W-1:0];
        ovf[OVF_UNK] <= ovf[OVF_UNK] | nx_unk[CNT_W];
      end
      if (inc_total) begin
        cnt_total      <= nx_total[CNT_W-1:0];
        ovf[OVF_TOTAL] <= ovf[OVF_TOTAL] | nx_total[CNT_W];
      end
    end
  end

`ifdef STATS_SUBCLASS_EN
  logic inc_br, inc_mem;
  logic [CNT_W:0] nx_br, nx_mem;

  assign inc_br  = s1_valid && s1_br;
  assign inc_mem = s1_valid && s1_mem;
  assign nx_br   = bump(cnt_br);
  assign nx_mem  = bump(cnt_mem);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_br  <= '0;
      cnt_mem <= '0;
      ovf[OVF_MEM:OVF_BR] <= '0;
    end else if (clear) begin
      cnt_br  <= '0;
      cnt_mem <= '0;
      ovf[OVF_MEM:OVF_BR] <= '0;
    end else begin
      if (inc_br) begin
        cnt_br      <= nx_br[CNT_W-1:0];
        ovf[OVF_BR] <= ovf[OVF_BR] | nx_br[CNT_W];
      end
      if (inc_mem) begin
        cnt_mem      <= nx_mem[CNT_W-1:0];
        ovf[OVF_MEM] <= ovf[OVF_MEM] | nx_mem[CNT_W];
      end
    end
  end
`endif

  // ---------------------------------------------------------------- snapshot
  // Captures the registered counter values, i.e. the state before any
  // increment or clear happening on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_valid <= 1'b0;
      snap_r     <= '0;
      snap_i     <= '0;
      snap_j     <= '0;
      snap_unk   <= '0;
      snap_total <= '0;
    end else begin
      snap_valid <= snap_req;
      if (snap_req) begin
        snap_r     <= cnt_r;
        snap_i     <= cnt_i;
        snap_j     <= cnt_j;
        snap_unk   <= cnt_unk;
        snap_total <= cnt_total;
      end
    end
  end

`ifdef STATS_SUBCLASS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_br  <= '0;
      snap_mem <= '0;
    end else if (snap_req) begin
      snap_br  <= cnt_br;
      snap_mem <= cnt_mem;
    end
  end
`endif

endmodule

// File: tb/tb_instr_class_stats.sv
// tb_instr_class_stats
// Directed bench for instr_class_stats. Three instances share the stimulus:
// a 32-bit saturating one, a 4-bit saturating one and a 4-bit wrapping one.
// A reference model keeps the unbounded number of counted events per
// counter since the last clear/reset; the expected register value, the
// overflow flag and the snapshot contents are derived from that count.
// Optional feature macro: STATS_SUBCLASS_EN (adds br/mem counters).

module tb_instr_class_stats;
  import mips_stats_pkg::*;

  localparam int NC = OVF_W;  // number of counters in this build

  // ------------------------------------------------------------ clock/reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       ret_valid = 1'b0;
  logic [5:0] ret_op    = 6'd0;
  logic       clear     = 1'b0;
  logic       snap_req  = 1'b0;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  // ------------------------------------------------------------ DUT wires
  logic [31:0] c0_r, c0_i, c0_j, c0_u, c0_t, s0_r, s0_i, s0_j, s0_u, s0_t;
  logic [3:0]  c1_r, c1_i, c1_j, c1_u, c1_t, s1_r, s1_i, s1_j, s1_u, s1_t;
  logic [3:0]  c2_r, c2_i, c2_j, c2_u, c2_t, s2_r, s2_i, s2_j, s2_u, s2_t;
  logic [OVF_W-1:0] ovf0, ovf1, ovf2;
  logic sv0, sv1, sv2;
  logic [63:0] live0[7], snp0[7], live1[7], snp1[7], live2[7], snp2[7];

`ifdef STATS_SUBCLASS_EN
  logic [31:0] c0_b, c0_m, s0_b, s0_m;
  logic [3:0]  c1_b, c1_m, s1_b, s1_m, c2_b, c2_m, s2_b, s2_m;
`endif

  instr_class_stats #(.CNT_W(32), .SATURATE(1'b1)) u_w32 (
    .clk(clk), .rst(rst), .ret_valid(ret_valid), .ret_op(ret_op),
    .clear(clear), .snap_req(snap_req),
    .cnt_r(c0_r), .cnt_i(c0_i), .cnt_j(c0_j), .cnt_unk(c0_u), .cnt_total(c0_t),
`ifdef STATS_SUBCLASS_EN
    .cnt_br(c0_b), .cnt_mem(c0_m), .snap_br(s0_b), .snap_mem(s0_m),
`endif
    .ovf(ovf0), .snap_valid(sv0),
    .snap_r(s0_r), .snap_i(s0_i), .snap_j(s0_j), .snap_unk(s0_u), .snap_total(s0_t)
  );

  instr_class_stats #(.CNT_W(4), .SATURATE(1'b1)) u_sat4 (
    .clk(clk), .rst(rst), .ret_valid(ret_valid), .ret_op(ret_op),
    .clear(clear), .snap_req(snap_req),
    .cnt_r(c1_r), .cnt_i(c1_i), .cnt_j(c1_j), .cnt_unk(c1_u), .cnt_total(c1_t),
`ifdef STATS_SUBCLASS_EN
    .cnt_br(c1_b), .cnt_mem(c1_m), .snap_br(s1_b), .snap_mem(s1_m),
`endif
    .ovf(ovf1), .snap_valid(sv1),
    .snap_r(s1_r), .snap_i(s1_i), .snap_j(s1_j), .snap_unk(s1_u), .snap_total(s1_t)
  );

  instr_class_stats #(.CNT_W(4), .SATURATE(1'b0)) u_wrap4 (
    .clk(clk), .rst(rst), .ret_valid(ret_valid), .ret_op(ret_op),
    .clear(clear), .snap_req(snap_req),
    .cnt_r(c2_r), .cnt_i(c2_i), .cnt_j(c2_j), .cnt_unk(c2_u), .cnt_total(c2_t),
`ifdef STATS_SUBCLASS_EN
    .cnt_br(c2_b), .cnt_mem(c2_m), .snap_br(s2_b), .snap_mem(s2_m),
`endif
    .ovf(ovf2), .snap_valid(sv2),
    .snap_r(s2_r), .snap_i(s2_i), .snap_j(s2_j), .snap_unk(s2_u), .snap_total(s2_t)
  );

  // Pack outputs into arrays indexed by the ovf bit positions
  assign live0[0] = 64'(c0_r); assign live0[1] = 64'(c0_i); assign live0[2] = 64'(c0_j);
  assign live0[3] = 64'(c0_u); assign live0[4] = 64'(c0_t);
  assign snp0[0]  = 64'(s0_r); assign snp0[1]  = 64'(s0_i); assign snp0[2]  = 64'(s0_j);
  assign snp0[3]  = 64'(s0_u); assign snp0[4]  = 64'(s0_t);
  assign live1[0] = 64'(c1_r); assign live1[1] = 64'(c1_i); assign live1[2] = 64'(c1_j);
  assign live1[3] = 64'(c1_u); assign live1[4] = 64'(c1_t);
  assign snp1[0]  = 64'(s1_r); assign snp1[1]  = 64'(s1_i); assign snp1[2]  = 64'(s1_j);
  assign snp1[3]  = 64'(s1_u); assign snp1[4]  = 64'(s1_t);
  assign live2[0] = 64'(c2_r); assign live2[1] = 64'(c2_i); assign live2[2] = 64'(c2_j);
  assign live2[3] = 64'(c2_u); assign live2[4] = 64'(c2_t);
  assign snp2[0]  = 64'(s2_r); assign snp2[1]  = 64'(s2_i); assign snp2[2]  = 64'(s2_j);
  assign snp2[3]  = 64'(s2_u); assign snp2[4]  = 64'(s2_t);
`ifdef STATS_SUBCLASS_EN
  assign live0[5] = 64'(c0_b); assign live0[6] = 64'(c0_m);
  assign snp0[5]  = 64'(s0_b); assign snp0[6]  = 64'(s0_m);
  assign live1[5] = 64'(c1_b); assign live1[6] = 64'(c1_m);
  assign snp1[5]  = 64'(s1_b); assign snp1[6]  = 64'(s1_m);
  assign live2[5] = 64'(c2_b); assign live2[6] = 64'(c2_m);
  assign snp2[5]  = 64'(s2_b); assign snp2[6]  = 64'(s2_m);
`else
  assign live0[5] = '0; assign live0[6] = '0; assign snp0[5] = '0; assign snp0[6] = '0;
  assign live1[5] = '0; assign live1[6] = '0; assign snp1[5] = '0; assign snp1[6] = '0;
  assign live2[5] = '0; assign live2[6] = '0; assign snp2[5] = '0; assign snp2[6] = '0;
`endif

  // ------------------------------------------------------------ model
  // m_cnt[k]: events counted into counter k since the last clear/reset,
  // without any width limit.
  longint m_cnt[7];
  longint m_snap[7];
  bit     m_snap_valid = 1'b0;
  bit     m_pend_valid = 1'b0;
  logic [5:0] m_pend_op = 6'd0;
  string  fld[7] = '{"r", "i", "j", "unk", "total", "br", "mem"};

  initial begin
    for (int k = 0; k < 7; k++) begin
      m_cnt[k]  = 0;
      m_snap[k] = 0;
    end
  end

  // Index of the class counter for an opcode, from the instruction table
  function automatic int model_class(input logic [5:0] op);
    if (op == 6'd0) return 0;
    if (op inside {6'b000010, 6'b000011}) return 2;
    if (op inside {6'b001000, 6'b001001, 6'b001010, 6'b001100, 6'b001101,
                   6'b000100, 6'b000101, 6'b100011, 6'b101011}) return 1;
    return 3;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 7; k++) begin
        m_cnt[k]  = 0;
        m_snap[k] = 0;
      end
      m_snap_valid = 1'b0;
      m_pend_valid = 1'b0;
    end else begin
      m_snap_valid = snap_req;
      if (snap_req) m_snap = m_cnt;
      if (clear) begin
        for (int k = 0; k < 7; k++) m_cnt[k] = 0;
      end else if (m_pend_valid) begin
        m_cnt[model_class(m_pend_op)] += 1;
        m_cnt[4] += 1;
        if (m_pend_op inside {6'b000100, 6'b000101}) m_cnt[5] += 1;
        if (m_pend_op inside {6'b100011, 6'b101011}) m_cnt[6] += 1;
      end
      m_pend_valid = ret_valid;
      m_pend_op    = ret_op;
    end
  end

  // Register value a counter shows after c events at width w
  function automatic logic [63:0] exp_val(input longint c, input int w, input bit sat);
    longint mx;
    mx = (longint'(1) <<< w) - 1;
    if (c <= mx) return 64'(c);
    if (sat) return 64'(mx);
    return 64'(c % (mx + 1));
  endfunction

  function automatic logic exp_ovf(input longint c, input int w);
    return c > ((longint'(1) <<< w) - 1);
  endfunction

  // ------------------------------------------------------------ scoreboard
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input string tag, input logic [63:0] lv[7],
                          input logic [63:0] sn[7], input logic [6:0] ov,
                          input logic sv, input int w, input bit sat);
    for (int k = 0; k < NC; k++) begin
      check($sformatf("%s cnt_%s", tag, fld[k]), lv[k], exp_val(m_cnt[k], w, sat));
      check($sformatf("%s ovf_%s", tag, fld[k]), 64'(ov[k]), 64'(exp_ovf(m_cnt[k], w)));
      check($sformatf("%s snap_%s", tag, fld[k]), sn[k], exp_val(m_snap[k], w, sat));
    end
    check($sformatf("%s snap_valid", tag), 64'(sv), 64'(m_snap_valid));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst("w32", live0, snp0, 7'(ovf0), sv0, 32, 1'b1);
      cmp_inst("sat4", live1, snp1, 7'(ovf1), sv1, 4, 1'b1);
      cmp_inst("wrap4", live2, snp2, 7'(ovf2), sv2, 4, 1'b0);
    end
  end

  // ------------------------------------------------------------ driver
  // Applies one cycle of inputs; returns 1 time unit after the edge.
  task automatic drive(input logic v, input logic [5:0] op, input logic clr, input logic snp);
    ret_valid = v;
    ret_op    = op;
    clear     = clr;
    snap_req  = snp;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 6'd0, 1'b0, 1'b0);
  endtask

  logic [5:0] mixed[7];

  initial begin
    mixed = '{6'b000000, 6'b000010, 6'b000011, 6'b001000, 6'b100011, 6'b101011, 6'b111111};

    // Reset then idle
    #2 rst = 1'b1;
    #1 chk_en = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    idle(5);
    check("reset cnt_total", 64'(c0_t), 64'd0);
    check("reset ovf", 64'(ovf0), 64'd0);
    check("reset snap_valid", 64'(sv0), 64'd0);

    // Mixed stream, one per cycle
    foreach (mixed[n]) drive(1'b1, mixed[n], 1'b0, 1'b0);
    idle(2);
    check("mixed cnt_r", 64'(c0_r), 64'd1);
    check("mixed cnt_j", 64'(c0_j), 64'd2);
    check("mixed cnt_i", 64'(c0_i), 64'd3);
    check("mixed cnt_unk", 64'(c0_u), 64'd1);
    check("mixed cnt_total", 64'(c0_t), 64'd7);
`ifdef STATS_SUBCLASS_EN
    check("mixed cnt_mem", 64'(c0_m), 64'd2);
    check("mixed cnt_br", 64'(c0_b), 64'd0);
`endif

    // Overflow on the 4-bit instances
    drive(1'b0, 6'd0, 1'b1, 1'b0);
    for (int n = 0; n < 17; n++) drive(1'b1, OP_RTYPE, 1'b0, 1'b0);
    idle(2);
    check("ovf sat4 cnt_r", 64'(c1_r), 64'd15);
    check("ovf sat4 cnt_total", 64'(c1_t), 64'd15);
    check("ovf sat4 ovf_r", 64'(ovf1[0]), 64'd1);
    check("ovf sat4 ovf_total", 64'(ovf1[4]), 64'd1);
    check("ovf wrap4 cnt_r", 64'(c2_r), 64'd1);
    check("ovf wrap4 cnt_total", 64'(c2_t), 64'd1);
    check("ovf wrap4 flags", 64'({ovf2[4], ovf2[0]}), 64'd3);
    check("ovf w32 cnt_r", 64'(c0_r), 64'd17);

    // Clear collision: ADDI at N, clear + BEQ at N+1
    drive(1'b0, 6'd0, 1'b1, 1'b0);
    idle(1);
    drive(1'b1, OP_ADDI, 1'b0, 1'b0);
    drive(1'b1, OP_BEQ, 1'b1, 1'b0);
    idle(1);
    check("clrcol cnt_i", 64'(c0_i), 64'd1);
    check("clrcol cnt_total", 64'(c0_t), 64'd1);
    check("clrcol ovf cleared", 64'(ovf1), 64'd0);
`ifdef STATS_SUBCLASS_EN
    check("clrcol cnt_br", 64'(c0_b), 64'd1);
`endif

    // Snapshot together with clear, a retire in flight
    drive(1'b0, 6'd0, 1'b1, 1'b0);
    for (int n = 0; n < 6; n++) drive(1'b1, mixed[n], 1'b0, 1'b0);
    check("snap pre cnt_total", 64'(c0_t), 64'd5);
    drive(1'b1, OP_SW, 1'b1, 1'b1);
    check("snap snap_valid", 64'(sv0), 64'd1);
    check("snap snap_total", 64'(s0_t), 64'd5);
    check("snap cnt_total", 64'(c0_t), 64'd0);
    idle(1);
    check("snap pulse end", 64'(sv0), 64'd0);
    check("snap held", 64'(s0_t), 64'd5);
    check("snap post cnt_total", 64'(c0_t), 64'd1);

    // Back-to-back snapshot requests
    drive(1'b1, OP_RTYPE, 1'b0, 1'b1);
    drive(1'b0, 6'd0, 1'b0, 1'b1);
    drive(1'b0, 6'd0, 1'b0, 1'b1);
    check("b2b snap_valid", 64'(sv0), 64'd1);
    check("b2b snap_total", 64'(s0_t), 64'd2);
    idle(1);

    // Every opcode once
    drive(1'b0, 6'd0, 1'b1, 1'b0);
    for (int n = 0; n < 64; n++) drive(1'b1, 6'(n), 1'b0, 1'b0);
    idle(2);
    check("sweep cnt_r", 64'(c0_r), 64'd1);
    check("sweep cnt_i", 64'(c0_i), 64'd9);
    check("sweep cnt_j", 64'(c0_j), 64'd2);
    check("sweep cnt_unk", 64'(c0_u), 64'd52);
    check("sweep cnt_total", 64'(c0_t), 64'd64);
`ifdef STATS_SUBCLASS_EN
    check("sweep cnt_br", 64'(c0_b), 64'd2);
    check("sweep cnt_mem", 64'(c0_m), 64'd2);
`endif

    // Async reset between edges during a burst
    drive(1'b0, 6'd0, 1'b0, 1'b1);
    for (int n = 0; n < 3; n++) drive(1'b1, OP_ORI, 1'b0, 1'b0);
    #2 rst = 1'b1;
    ret_valid = 1'b0;
    #1;
    check("arst cnt_total", 64'(c0_t), 64'd0);
    check("arst cnt_i", 64'(c0_i), 64'd0);
    check("arst snap_total", 64'(s0_t), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(3);
    check("arst inflight lost", 64'(c0_t), 64'd0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_class_stats.md
Name: instr_class_stats

Overview:
- Sequential successor to the combinational opcode classifier.
- Decodes the 6-bit MIPS opcode of each retired instruction into a class (R, I, J or unknown).
- Keeps a parametrised-width counter per class plus a total, with sticky overflow flags, synchronous clear and a snapshot handshake.
- Sits beside the writeback stage and is driven by the retire-valid strobe.

Parameters:
- CNT_W, 32, width of every counter and snapshot register (min 4).
- SATURATE, 1, 1 = counters hold at all-ones on overflow; 0 = counters wrap to 0.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ret_valid  in  1  an instruction retires this cycle
- ret_op  in  6  opcode of the retiring instruction
- clear  in  1  synchronous clear of counters and overflow flags
- snap_req  in  1  request a coherent snapshot of all counters
- cnt_r, cnt_i, cnt_j, cnt_unk, cnt_total  out  CNT_W each  live counters
- ovf  out  5  sticky overflow flags {total, unk, j, i, r}
- snap_valid  out  1  one-cycle pulse: the snap_* outputs were updated
- snap_r, snap_i, snap_j, snap_unk, snap_total  out  CNT_W each  snapshot registers

Behaviour:
- Class decode:
  - R = 000000.
  - J = 000010, 000011.
  - I = 001000, 001001, 001010, 001100, 001101, 000100, 000101, 100011, 101011.
  - Every other opcode = unknown.
- Reset (async, rst=1): all counters, ovf, snap_* = 0; snap_valid = 0; stage-1 valid = 0.
- Stage 1 (one register stage), each edge: s1_valid <= ret_valid; s1_cls <= decode(ret_op).
- Stage 2: if s1_valid, the counter for s1_cls and cnt_total each increment by 1.
- Latency: instruction sampled at edge N is visible on the live counters after edge N+1.
- Throughput: one instruction per cycle, no back-pressure.
- Overflow: an increment from all-ones sets that counter's ovf bit (sticky).
  - SATURATE=1: the counter stays at all-ones.
  - SATURATE=0: the counter becomes 0.
  - total and its class counter are handled independently.
- Clear, at the edge where clear=1:
  - All live counters and ovf become 0.
  - The stage-1 entry at that edge is discarded (not counted).
  - ret_valid/ret_op at that edge are still captured into stage 1 and counted on the next edge.
  - snap_* registers are unaffected.
- Snapshot, at the edge where snap_req=1:
  - snap_* capture the live counter values present before that edge, so any increment or clear at the same edge is excluded.
  - snap_valid = 1 for exactly the following cycle.
  - Back-to-back requests give consecutive snap_valid pulses, each with fresh data.
- clear and snap_req together: the snapshot takes pre-clear values and the counters go to 0.
- Reset mid-operation: everything, including the in-flight stage-1 entry, is lost immediately.

Optional Feature:
- Macro: STATS_SUBCLASS_EN.
- When defined:
  - Adds outputs cnt_br and cnt_mem (CNT_W) and snap_br and snap_mem.
  - ovf widens to 7 bits {mem, br, total, unk, j, i, r}.
  - cnt_br counts BEQ/BNE (000100, 000101); cnt_mem counts LW/SW (100011, 101011).
  - These instructions still count as I.
  - Same latency, clear, snapshot and overflow rules as the other counters.
- When undefined: these ports and registers are absent and ovf is 5 bits.

Decomposition:
- Shared package/header mips_stats_pkg:
  - Opcode constants (OP_RTYPE, OP_J, OP_JAL, OP_ADDI, ... OP_SW).
  - Class encoding: CLS_R=0, CLS_I=1, CLS_J=2, CLS_UNK=3 (2 bits).
  - ovf bit-index constants.
- One sub-module: op_class_decode.
  - Purely combinational: op -> 2-bit class, plus is_br/is_mem flags.
  - Reused by the existing classifier bench.

Test Plan:
- Reset then idle: rst pulse, ret_valid=0 for 5 cycles -> all counters 0, ovf=0, snap_valid never high.
- Mixed stream, one per cycle:
  - Stimulus: 000000, 000010, 000011, 001000, 100011, 101011, 111111.
  - Two cycles after the last: cnt_r=1, cnt_j=2, cnt_i=3, cnt_unk=1, cnt_total=7.
  - With STATS_SUBCLASS_EN: cnt_mem=2, cnt_br=0.
- Overflow, CNT_W=4:
  - SATURATE=1: 17 R-type -> cnt_r=15, cnt_total=15, ovf[0]=1, ovf[4]=1.
  - SATURATE=0: same stream -> cnt_r=1, cnt_total=1, both flags set.
- Clear collision:
  - Stimulus: ADDI at edge N, clear + BEQ at edge N+1.
  - After edge N+2: cnt_i=1, cnt_total=1 (the ADDI is discarded, the BEQ is counted).
- Snapshot:
  - Stimulus: with cnt_total=5 and a retire in flight, assert snap_req and clear together.
  - Next cycle: snap_valid=1, snap_total=5, cnt_total=0.
  - Following cycle: snap_valid=0.
- Async reset mid-stream: assert rst between edges during a burst -> counters go to 0 without waiting for an edge, and the in-flight instruction is never counted.
